// File: rtl/store_buffer_pkg.sv
// Shared types for the posted-write store buffer.
// Entry layout and arbitration states.
package store_buffer_pkg;

  localparam int SB_ADDR_W = 32;
  localparam int SB_DATA_W = 32;

  typedef struct packed {
    logic [SB_ADDR_W-1:0] addr;
    logic [SB_DATA_W-1:0] data;
  } sb_entry_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    FORCE  = 2'd2
  } sb_state_t;

endpackage

// File: rtl/store_buffer_match.sv
// Parallel address compare over buffered stores.
// Youngest-first select: scans back from tail-1.
module store_buffer_match
  import store_buffer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic [DEPTH-1:0]             valid,
  input  logic [DEPTH-1:0][ADDR_W-1:0] addrs,
  input  logic [$clog2(DEPTH)-1:0]     tail,
  input  logic [ADDR_W-1:0]            key,
  output logic                         hit,
  output logic [$clog2(DEPTH)-1:0]     idx
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] p;

  always_comb begin
    hit = 1'b0;
    idx = '0;
    p   = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      p = tail - PTR_W'(k);
      if (!hit && valid[p] &&
          addrs[p] == key) begin
        hit = 1'b1;
        idx = p;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer with bounded-starvation drain.
// STORE_FWD_EN: forward buffered data to loads instead of stalling.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = SB_ADDR_W,
  parameter int DATA_W    = SB_DATA_W,
  parameter int MAX_DEFER = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [ADDR_W-1:0]        st_addr,
  input  logic [DATA_W-1:0]        st_data,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [ADDR_W-1:0]        ld_addr,
  output logic [DATA_W-1:0]        ld_data,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic                     mem_we,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int DEF_W = $clog2(MAX_DEFER + 1);

  sb_entry_t        entries [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic [DEF_W-1:0] defer_cnt;
  logic [DEF_W-1:0] defer_n;
  sb_state_t        state;
  sb_state_t        state_n;

  logic push;
  logic drain;
  logic grant_ld;
  logic hazard;
  logic is_empty;
  logic forced;

  logic [DEPTH-1:0]             ent_valid;
  logic [DEPTH-1:0][ADDR_W-1:0] ent_addrs;
  logic                         hit;
  logic [PTR_W-1:0]             hit_idx;
  logic [PTR_W-1:0]             off;

  always_comb begin
    ent_valid = '0;
    ent_addrs = '0;
    off       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off          = PTR_W'(i) - head;
      ent_valid[i] = CNT_W'(off) < cnt;
      ent_addrs[i] = ADDR_W'(entries[i].addr);
    end
  end

  store_buffer_match #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_match (
    .valid (ent_valid),
    .addrs (ent_addrs),
    .tail  (tail),
    .key   (ld_addr),
    .hit   (hit),
    .idx   (hit_idx)
  );

`ifdef STORE_FWD_EN
  assign hazard  = 1'b0;
  assign ld_data = hit
    ? DATA_W'(entries[hit_idx].data)
    : mem_rdata;
`else
  logic unused_idx;
  assign unused_idx = ^hit_idx;
  assign hazard     = hit;
  assign ld_data    = mem_rdata;
`endif

  assign is_empty = cnt == '0;
  assign forced   = state == FORCE;
  assign st_ready = cnt < CNT_W'(DEPTH);
  assign push     = st_valid && st_ready;
  assign grant_ld = ld_valid && !forced
                 && !hazard;
  assign drain    = !grant_ld && !is_empty;

  assign ld_ready  = grant_ld;
  assign mem_we    = drain;
  assign mem_wdata = DATA_W'(entries[head].data);
  assign mem_addr  = drain
    ? ADDR_W'(entries[head].addr)
    : ld_addr;

  assign empty = is_empty;
  assign count = cnt;

  assign cnt_n = cnt + CNT_W'(push)
               - CNT_W'(drain);

  // Deferral only accrues while loads keep
  // beating a non-empty buffer to the port.
  always_comb begin
    defer_n = '0;
    if (!drain && grant_ld && !is_empty)
      defer_n = defer_cnt + DEF_W'(1);
  end

  always_comb begin
    state_n = ACTIVE;
    if (cnt_n == '0)
      state_n = IDLE;
    else if (defer_n == DEF_W'(MAX_DEFER))
      state_n = FORCE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head      <= '0;
      tail      <= '0;
      cnt       <= '0;
      defer_cnt <= '0;
      state     <= IDLE;
    end else begin
      if (push)
        tail <= tail + PTR_W'(1);
      if (drain)
        head <= head + PTR_W'(1);
      cnt       <= cnt_n;
      defer_cnt <= defer_n;
      state     <= state_n;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      entries[tail].addr <= SB_ADDR_W'(st_addr);
      entries[tail].data <= SB_DATA_W'(st_data);
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Randomized bench for store_buffer against a queue model.
// Model follows STORE_FWD_EN the same way as the design.
module tb_store_buffer;

  localparam int DEPTH = 4;
  localparam int MAXD  = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_valid, st_ready;
  logic [31:0] st_addr, st_data;
  logic        ld_valid, ld_ready;
  logic [31:0] ld_addr, ld_data;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, empty;
  logic [2:0]  count;
  logic        mem_clr;

  always #5 clk = ~clk;

  store_buffer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .st_valid  (st_valid),
    .st_ready  (st_ready),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .empty     (empty),
    .count     (count)
  );

  logic [31:0] mem [0:255];
  assign mem_rdata = mem[mem_addr[7:0]];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++)
        mem[i] <= '0;
    end else if (mem_we) begin
      mem[mem_addr[7:0]] <= mem_wdata;
    end
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];
  logic [31:0] ref_mem [0:255];
  int          won;
  int          checks = 0;
  int          errors = 0;

  logic        obs_ld_ready, obs_we;
  logic        obs_st_ready;
  logic [31:0] obs_ld_data;

  task automatic chk(input string tag,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h",
               tag, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    won = 0;
  endtask

  task automatic step();
    bit          hit, haz, g, dr, full, emp, psh;
    logic [31:0] hd, expd;
    ent_t        e;
    @(negedge clk);
    hit  = 0;
    hd   = '0;
    full = q.size() == DEPTH;
    emp  = q.size() == 0;
    for (int i = q.size() - 1; i >= 0; i--)
      if (!hit && q[i].a == ld_addr) begin
        hit = 1;
        hd  = q[i].d;
      end
`ifdef STORE_FWD_EN
    haz = 0;
`else
    haz = hit;
`endif
    g  = ld_valid && (won != MAXD) && !haz;
    dr = !g && !emp;
    obs_ld_ready = ld_ready;
    obs_we       = mem_we;
    obs_st_ready = st_ready;
    obs_ld_data  = ld_data;
    chk("count", count, q.size());
    chk("empty", empty, emp);
    chk("st_ready", st_ready, !full);
    chk("ld_ready", ld_ready, g);
    chk("mem_we", mem_we, dr);
    if (dr) begin
      chk("drain_addr", mem_addr, q[0].a);
      chk("drain_data", mem_wdata, q[0].d);
    end else begin
      chk("mem_addr", mem_addr, ld_addr);
    end
    if (g) begin
      expd = ref_mem[ld_addr[7:0]];
`ifdef STORE_FWD_EN
      if (hit) expd = hd;
`endif
      chk("ld_data", ld_data, expd);
    end
    psh = st_valid && !full;
    e.a = st_addr;
    e.d = st_data;
    @(posedge clk);
    if (dr) begin
      ref_mem[q[0].a[7:0]] = q[0].d;
      void'(q.pop_front());
    end
    if (psh) q.push_back(e);
    if (dr) won = 0;
    else if (g && !emp) won++;
    else won = 0;
    #1;
  endtask

  task automatic idle_drain(input int n);
    st_valid = 0;
    ld_valid = 0;
    repeat (n) step();
  endtask

  initial begin
    int n, i, guard;
    rst_n    = 0;
    st_valid = 0;
    st_addr  = '0;
    st_data  = '0;
    ld_valid = 0;
    ld_addr  = '0;
    mem_clr  = 1;
    for (int k = 0; k < 256; k++)
      ref_mem[k] = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    mem_clr = 0;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_st_ready", st_ready, 1);
    chk("rst_we", mem_we, 0);
    chk("rst_ld_ready", ld_ready, 0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;

    // Reset while draining three entries
    ld_valid = 1;
    ld_addr  = 40;
    for (int k = 0; k < 3; k++) begin
      st_valid = 1;
      st_addr  = 30 + k;
      st_data  = 32'h300 + k;
      step();
    end
    st_valid = 0;
    ld_valid = 0;
    #1;
    chk("pre_rst_we", mem_we, 1);
    rst_n = 0;
    #1;
    chk("mid_rst_we", mem_we, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_st_ready", st_ready, 1);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    step();
    chk("no_write_30", mem[30], 0);

    // Fill with loads held, then starvation-bounded drain
    ld_valid = 1;
    ld_addr  = 8;
    for (int k = 0; k < 5; k++) begin
      st_valid = 1;
      st_addr  = k;
      st_data  = 32'hA0 + k;
      step();
    end
    chk("fill_full", obs_st_ready, 0);
    st_valid = 0;
    repeat (40) step();
    idle_drain(4);
    for (int k = 0; k < 4; k++)
      chk("fill_mem", mem[k], 32'hA0 + k);
    chk("fill_no5th", mem[4], 0);

    // Same-address stores then load
    ld_valid = 1;
    ld_addr  = 7;
    st_valid = 1;
    st_addr  = 5;
    st_data  = 32'h11;
    step();
    st_data  = 32'h22;
    step();
    st_valid = 0;
    ld_addr  = 5;
    step();
`ifdef STORE_FWD_EN
    chk("fwd_ready", obs_ld_ready, 1);
    chk("fwd_data", obs_ld_data, 32'h22);
`else
    chk("stall_ready", obs_ld_ready, 0);
    guard = 0;
    while (!obs_ld_ready && guard < 10) begin
      step();
      guard++;
    end
    chk("stall_done", obs_ld_ready, 1);
    chk("stall_data", obs_ld_data, 32'h22);
    chk("stall_drained", guard, 2);
`endif
    idle_drain(6);

    // Starvation bound with a single entry
    st_valid = 1;
    st_addr  = 3;
    st_data  = 32'h55;
    step();
    st_valid = 0;
    ld_valid = 1;
    ld_addr  = 9;
    n = 0;
    guard = 0;
    obs_we = 0;
    while (!obs_we && guard < 20) begin
      step();
      if (obs_ld_ready) n++;
      guard++;
    end
    chk("starve_grants", n, MAXD);
    chk("starve_forced", obs_we, 1);
    chk("starve_blocked", obs_ld_ready, 0);
    step();
    chk("starve_resume", obs_ld_ready, 1);
    idle_drain(3);

    // Push and pop in the same cycle
    ld_valid = 1;
    ld_addr  = 50;
    for (int k = 0; k < 2; k++) begin
      st_valid = 1;
      st_addr  = 60 + k;
      st_data  = 32'h600 + k;
      step();
    end
    ld_valid = 0;
    st_addr  = 62;
    st_data  = 32'h602;
    step();
    chk("pushpop_cnt", count, 2);
    idle_drain(4);

    // Ten stores through the ring
    i = 0;
    guard = 0;
    ld_addr = 100;
    while (i < 10 && guard < 200) begin
      st_valid = 1;
      st_addr  = 16 + i;
      st_data  = 32'hB0 + i;
      ld_valid = $urandom_range(0, 1);
      step();
      if (obs_st_ready) i++;
      guard++;
    end
    chk("wrap_accepted", i, 10);
    idle_drain(12);
    for (int k = 0; k < 10; k++)
      chk("wrap_mem", mem[16 + k], 32'hB0 + k);

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      st_valid = $urandom_range(0, 1);
      st_addr  = $urandom_range(0, 15);
      st_data  = $urandom;
      ld_valid = $urandom_range(0, 9) < 6;
      ld_addr  = $urandom_range(0, 15);
      step();
    end
    idle_drain(8);
    for (int k = 0; k < 16; k++)
      chk("final_mem", mem[k], ref_mem[k]);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
